// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial binary-to-BCD converter.
package bcd_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;
    localparam logic [DIGIT_W-1:0] NINE       = 4'h9;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_e;

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational add-3 correction for one BCD digit ahead of the left shift.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);

    assign dout = (din >= DIGIT_W'(5)) ? din + DIGIT_W'(3) : din;

endmodule

// File: rtl/bcd_serial_conv.sv
// Serial shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Define BCD_BLANK_EN to output leading zero digits as the blank code.
module bcd_serial_conv
    import bcd_pkg::*;
#(
    parameter int BINARY_WIDTH = 32,
    parameter int DIGITS       = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [BINARY_WIDTH-1:0]   binary,
    output logic [DIGIT_W*DIGITS-1:0] bcd,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BINARY_WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(BINARY_WIDTH);
    localparam logic [BCD_W-1:0] SAT_VALUE = {DIGITS{NINE}};
`ifdef BCD_BLANK_EN
    localparam logic [BCD_W-1:0] BCD_RST   = {{(DIGITS-1){BLANK_CODE}}, DIGIT_W'(0)};
`else
    localparam logic [BCD_W-1:0] BCD_RST   = '0;
`endif

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BINARY_WIDTH-1:0] shreg_q, shreg_d;
    logic [BCD_W-1:0]        scratch_q, scratch_d;
    logic                    sticky_q, sticky_d;
    logic [BCD_W-1:0]        bcd_q, bcd_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    overflow_q, overflow_d;

    logic [BCD_W-1:0]        scratch_adj;
    logic [BCD_W-1:0]        scratch_next;
    logic [BINARY_WIDTH-1:0] shreg_next;
    logic                    ovf_bit;
    logic [BCD_W-1:0]        result;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scratch_q[g*DIGIT_W +: DIGIT_W]),
            .dout (scratch_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // A 1 leaving the top digit means the value needs more than DIGITS digits.
    assign ovf_bit      = scratch_adj[BCD_W-1];
    assign scratch_next = {scratch_adj[BCD_W-2:0], shreg_q[BINARY_WIDTH-1]};
    assign shreg_next   = shreg_q << 1;

`ifdef BCD_BLANK_EN
    function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] raw);
        logic lead;
        blank_leading = raw;
        lead          = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lead && raw[i*DIGIT_W +: DIGIT_W] == DIGIT_W'(0))
                blank_leading[i*DIGIT_W +: DIGIT_W] = BLANK_CODE;
            else
                lead = 1'b0;
        end
    endfunction

    assign result = blank_leading(scratch_q);
`else
    assign result = scratch_q;
`endif

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through this block can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        scratch_d  = scratch_q;
        sticky_d   = sticky_q;
        bcd_d      = bcd_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d   = binary;
                    scratch_d = '0;
                    sticky_d  = 1'b0;
                    cnt_d     = CNT_LOAD;
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = scratch_next;
                shreg_d   = shreg_next;
                sticky_d  = sticky_q | ovf_bit;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1))
                    state_d = FINISH;
            end
            FINISH: begin
                bcd_d      = sticky_q ? SAT_VALUE : result;
                overflow_d = sticky_q;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sticky_q   <= 1'b0;
            bcd_q      <= BCD_RST;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sticky_q   <= sticky_d;
            bcd_q      <= bcd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the datapath registers are left without reset; each accepted start reloads them before use.
    always_ff @(posedge clk) begin
        shreg_q   <= shreg_d;
        scratch_q <= scratch_d;
    end

    assign bcd      = bcd_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule
